fpalu_sub_seq: RTL and testbench

//  Multi-cycle IEEE-754 single-precision subtractor: sum = a_in - b_in (computed as a_in + (-b_in)).

---
 rtl/fpalu_sub_seq_pkg.sv | 38 +++
 rtl/fpalu_sub_seq_if.sv | 25 ++
 rtl/fpalu_sub_seq_align_shift.sv | 19 +
 rtl/fpalu_sub_seq.sv | 152 +++++++++++++++
 tb/tb_fpalu_sub_seq.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpalu_sub_seq_pkg.sv
// Shared types and constants for the sequential single-precision subtractor.
package fpalu_sub_seq_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MAN_W  = 23;
  localparam int unsigned BIAS   = 127;
  localparam int unsigned WORD_W = 1 + EXP_W + MAN_W;
  // Working mantissa: {carry, hidden, stored mantissa}
  localparam int unsigned WMAN_W = MAN_W + 2;

  localparam logic [EXP_W-1:0]  EXP_MAX     = 8'hFF;
  localparam logic [WORD_W-1:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [WORD_W-1:0] FP_POS_INF  = 32'h7F80_0000;

  typedef enum logic [2:0] {
    StIdle,
    StAlign,
    StAdd,
    StNorm,
    StDone
  } state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [WMAN_W-1:0] man;
  } operand_t;

  // Exponent zero is a true zero: the stored mantissa is discarded and no hidden bit is added.
  function automatic operand_t fp_unpack(logic [WORD_W-1:0] w);
    operand_t o;
    o.sign = w[WORD_W-1];
    o.exp  = w[WORD_W-2:MAN_W];
    o.man  = (o.exp == '0) ? '0 : {2'b01, w[MAN_W-1:0]};
    return o;
  endfunction

endpackage

// File: rtl/fpalu_sub_seq_if.sv
// Operand/result handshake bundle for the sequential subtractor.
interface fpalu_sub_seq_if;
  import fpalu_sub_seq_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] a_in;
  logic [WORD_W-1:0] b_in;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] sum;
  logic              ovf;
  logic              uf;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, sum, ovf, uf
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, sum, ovf, uf
  );

endinterface

// File: rtl/fpalu_sub_seq_align_shift.sv
// Right barrel shifter for mantissa alignment; shift amounts past the word width give zero.
module fpalu_sub_seq_align_shift
  import fpalu_sub_seq_pkg::*;
(
  input  logic [WMAN_W-1:0] man_i,
  input  logic [EXP_W-1:0]  amt_i,
  output logic [WMAN_W-1:0] man_o
);

  // Saturate: any amount >= the working width shifts everything out.
  always_comb begin
    if (amt_i >= EXP_W'(WMAN_W)) begin
      man_o = '0;
    end else begin
      man_o = man_i >> amt_i;
    end
  end

endmodule

// File: rtl/fpalu_sub_seq.sv
// Multi-cycle single-precision subtractor: sum = a_in - b_in, one operation in flight,
// normalisation one bit per cycle, truncating rounding, no denormals/NaN/Inf semantics.
module fpalu_sub_seq
  import fpalu_sub_seq_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  fpalu_sub_seq_if.slave bus
);

  state_e            state_q, state_d;
  operand_t          opa_q, opa_d;
  operand_t          opb_q, opb_d;
  logic [WORD_W-1:0] sum_q, sum_d;
  logic              ovf_q, ovf_d;
  logic              uf_q, uf_d;

  operand_t          lg_op, sm_op;
  logic [EXP_W-1:0]  shamt;
  logic [WMAN_W-1:0] sm_shifted;
  logic [WMAN_W-1:0] add_res;
  logic [EXP_W:0]    exp_inc;

  // Order operands by {exp, man} magnitude; larger goes first so the difference is never negative.
  always_comb begin
    if ({opa_q.exp, opa_q.man[MAN_W-1:0]} >= {opb_q.exp, opb_q.man[MAN_W-1:0]}) begin
      lg_op = opa_q;
      sm_op = opb_q;
    end else begin
      lg_op = opb_q;
      sm_op = opa_q;
    end
    // A zero smaller operand has mantissa 0, so its (meaningless) shift amount is harmless.
    shamt = lg_op.exp - sm_op.exp;
  end

  fpalu_sub_seq_align_shift u_align_shift (
    .man_i (sm_op.man),
    .amt_i (shamt),
    .man_o (sm_shifted)
  );

  // Magnitude add/subtract of the aligned pair and the carry-path exponent.
  always_comb begin
    if (opa_q.sign == opb_q.sign) begin
      add_res = opa_q.man + opb_q.man;
    end else begin
      add_res = opa_q.man - opb_q.man;
    end
    exp_inc = {1'b0, opa_q.exp} + (EXP_W+1)'(1);
  end

  // Next-state and datapath updates for the FSM.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    uf_d    = uf_q;

    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          opa_d   = fp_unpack(bus.a_in);
          opb_d   = fp_unpack({~bus.b_in[WORD_W-1], bus.b_in[WORD_W-2:0]});
          ovf_d   = 1'b0;
          uf_d    = 1'b0;
          state_d = StAlign;
        end
      end

      StAlign: begin
        opa_d     = lg_op;
        opb_d     = sm_op;
        opb_d.man = sm_shifted;
        state_d   = StAdd;
      end

      StAdd: begin
        if (add_res == '0) begin
          // Exact cancellation always yields +0 regardless of operand signs.
          sum_d   = FP_POS_ZERO;
          ovf_d   = 1'b0;
          uf_d    = 1'b0;
          state_d = StDone;
        end else begin
          opa_d.man = add_res;
          state_d   = StNorm;
        end
      end

      StNorm: begin
        if (opa_q.man[WMAN_W-1]) begin
          // Carry out: a single right shift always lands the leading one on the hidden bit.
          if (exp_inc >= {1'b0, EXP_MAX}) begin
            ovf_d = 1'b1;
            sum_d = {opa_q.sign, EXP_MAX, {MAN_W{1'b0}}};
          end else begin
            sum_d = {opa_q.sign, exp_inc[EXP_W-1:0], opa_q.man[MAN_W:1]};
          end
          state_d = StDone;
        end else if (opa_q.man[MAN_W]) begin
          sum_d   = {opa_q.sign, opa_q.exp, opa_q.man[MAN_W-1:0]};
          state_d = StDone;
        end else if (opa_q.exp == EXP_W'(1)) begin
          // Another left shift would take the exponent to 0: flush to +0.
          sum_d   = FP_POS_ZERO;
          uf_d    = 1'b1;
          state_d = StDone;
        end else begin
          opa_d.man = {opa_q.man[WMAN_W-2:0], 1'b0};
          opa_d.exp = opa_q.exp - EXP_W'(1);
        end
      end

      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      uf_q    <= uf_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.sum       = sum_q;
  assign bus.ovf       = ovf_q;
  assign bus.uf        = uf_q;

endmodule

// File: tb/tb_fpalu_sub_seq.sv
// Scoreboard bench for fpalu_sub_seq: driver pushes model results, monitor pops and compares.
module tb_fpalu_sub_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpalu_sub_seq_if bus ();

  fpalu_sub_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic        ovf;
    logic        uf;
    int          lat;
    int          cap;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp    = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  bit   rand_rdy = 1'b0;
  bit   hold     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: value-level subtraction following the decode/alignment/truncation rules.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] nb, lw, sw;
    longint      ka, kb, ml, ms, r, tmp;
    int          el, es, d, p, k;
    nb = {~b[31], b[30:0]};
    ka = (a[30:23] == 8'd0) ? 0 : longint'(a[30:0]);
    kb = (nb[30:23] == 8'd0) ? 0 : longint'(nb[30:0]);
    if (ka >= kb) begin lw = a;  sw = nb; end
    else          begin lw = nb; sw = a;  end
    el = int'(lw[30:23]);
    es = int'(sw[30:23]);
    ml = (el == 0) ? 0 : (longint'(lw[22:0]) + 64'h80_0000);
    ms = (es == 0) ? 0 : (longint'(sw[22:0]) + 64'h80_0000);
    d  = el - es;
    ms = (d >= 25) ? 0 : (ms >> d);
    r  = (lw[31] == sw[31]) ? (ml + ms) : (ml - ms);
    e.a = a; e.b = b; e.sum = 32'h0; e.ovf = 1'b0; e.uf = 1'b0; e.cap = 0;
    if (r == 0) begin
      e.lat = 3;
    end else begin
      p = 0;
      for (int i = 0; i < 25; i++) if (r[i]) p = i;
      if (p == 24) begin
        e.lat = 4;
        if (el + 1 >= 255) begin
          e.ovf = 1'b1;
          e.sum = {lw[31], 8'hFF, 23'h0};
        end else begin
          tmp   = r >> 1;
          e.sum = {lw[31], 8'(el + 1), tmp[22:0]};
        end
      end else begin
        k = 23 - p;
        if (k >= el) begin
          e.uf  = 1'b1;
          e.lat = 3 + el;
        end else begin
          tmp   = r << k;
          e.sum = {lw[31], 8'(el - k), tmp[22:0]};
          e.lat = 4 + k;
        end
      end
    end
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    bus.out_ready = hold ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  // Monitor: first cycle of out_valid pops and checks; held cycles must keep the same result.
  initial begin
    bit   seen = 1'b0;
    exp_t cur;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_output: actual sum %h required no output", bus.sum);
            cur.sum = bus.sum; cur.ovf = bus.ovf; cur.uf = bus.uf;
          end else begin
            cur = sb_q.pop_front();
            check($sformatf("sum(%h-%h)", cur.a, cur.b), bus.sum, cur.sum);
            check($sformatf("ovf(%h-%h)", cur.a, cur.b), 32'(bus.ovf), 32'(cur.ovf));
            check($sformatf("uf(%h-%h)", cur.a, cur.b), 32'(bus.uf), 32'(cur.uf));
            check($sformatf("latency(%h-%h)", cur.a, cur.b), 32'(cyc - cur.cap + 1),
                  32'(cur.lat));
          end
        end else begin
          check("held_sum", bus.sum, cur.sum);
        end
      end else begin
        seen = 1'b0;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit track);
    exp_t e;
    int   w;
    e = model(a, b);
    @(negedge clk);
    bus.a_in     = a;
    bus.b_in     = b;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL in_ready_timeout: actual 0 required 1 within 300 cycles");
      bus.in_valid = 1'b0;
      return;
    end
    e.cap = cyc + 1;
    if (track) sb_q.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a_in     = $urandom;
    bus.b_in     = $urandom;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb_q.size() != 0 || bus.out_valid) && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (sb_q.size() != 0 || bus.out_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: actual %0d pending required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    int          sel, w;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.a_in     = 32'h0;
    bus.b_in     = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", bus.sum, 32'h0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_uf", 32'(bus.uf), 32'd0);
    rst = 1'b0;

    issue(32'h3FC0_0000, 32'h3F80_0000, 1'b1);
    issue(32'h3F80_0000, 32'hBF80_0000, 1'b1);
    issue(32'h4040_0000, 32'h4040_0000, 1'b1);
    issue(32'h0000_0000, 32'h3F80_0000, 1'b1);
    issue(32'h3F80_0000, 32'h3F80_0001, 1'b1);
    issue(32'h7F7F_FFFF, 32'hFF7F_FFFF, 1'b1);
    issue(32'h0080_0001, 32'h0080_0000, 1'b1);
    drain();

    // Hold the result in DONE while input side is exercised.
    hold = 1'b1;
    issue(32'h3FC0_0000, 32'h3F80_0000, 1'b1);
    w = 0;
    while (!bus.out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.a_in     = $urandom;
      @(negedge clk);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    hold = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    // Reset in the middle of a long normalisation: the aborted operation must not appear.
    issue(32'h3F80_0000, 32'h3F80_0001, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_sum", bus.sum, 32'h0);
    rst = 1'b0;
    issue(32'h3FC0_0000, 32'h3F80_0000, 1'b1);
    drain();
    repeat (30) @(negedge clk);

    rand_rdy = 1'b1;
    for (int n = 0; n < 160; n++) begin
      sel = $urandom_range(0, 5);
      a   = $urandom;
      b   = $urandom;
      case (sel)
        0, 1: ;
        2: b = {a[31], a[30:23], a[22:0] ^ 23'($urandom_range(0, 15))};
        3: b = {a[31], a[30:23] - 8'd1, 23'($urandom)};
        4: begin
          if ($urandom_range(0, 1) == 1) a[30:23] = 8'd0;
          else b[30:23] = 8'd0;
        end
        default: begin
          a[30:23] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 2))
                                                  : 8'($urandom_range(254, 255));
          b[30:23] = a[30:23] ^ 8'($urandom_range(0, 1));
        end
      endcase
      issue(a, b, 1'b1);
    end
    drain();
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
